// File: rtl/seq_detect_param_if.sv
// Serial-stream and status bundle for seq_detect_param; master drives the stream, slave is the detector.
// Optional mask signals exist only when SEQDET_MASK_EN is defined.
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             din_vld;
  logic             din;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;
  logic [PAT_W-1:0] pat_q;
`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] mask_in;
  logic [PAT_W-1:0] mask_q;

  modport master (
    output din_vld, din, overlap, pat_load, pat_in, cnt_clr, mask_in,
    input  dout, match_cnt, pat_q, mask_q
  );
  modport slave (
    input  din_vld, din, overlap, pat_load, pat_in, cnt_clr, mask_in,
    output dout, match_cnt, pat_q, mask_q
  );
`else
  modport master (
    output din_vld, din, overlap, pat_load, pat_in, cnt_clr,
    input  dout, match_cnt, pat_q
  );
  modport slave (
    input  din_vld, din, overlap, pat_load, pat_in, cnt_clr,
    output dout, match_cnt, pat_q
  );
`endif
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with reloadable pattern and saturating match counter.
// Latency: dout pulses 1 clk after the edge consuming the last pattern bit.
// Backpressure: none; din_vld=0 simply stalls history. SEQDET_MASK_EN adds a don't-care mask.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1110,
  parameter int               CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_param_if.slave bus
);
  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  sr;
  logic [PAT_W-1:0]  sr_n;
  logic [PAT_W-1:0]  pat_q;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_n;
  logic              consume;
  logic              hit;
  logic              match;
  logic              dout;
  logic [CNT_W-1:0]  cnt;
`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0]  mask_q;
`endif

  // A load cycle discards the incoming bit, so it never counts as consumed.
  always_comb begin
    consume = bus.din_vld & ~bus.pat_load;
    sr_n    = {sr[PAT_W-2:0], bus.din};
    fill_n  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
`ifdef SEQDET_MASK_EN
    hit     = (((sr_n ^ pat_q) & mask_q) == '0);
`else
    hit     = (sr_n == pat_q);
`endif
    match   = consume && (fill_n == FILL_FULL) && hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      fill   <= '0;
      pat_q  <= PAT_RST;
      dout   <= 1'b0;
`ifdef SEQDET_MASK_EN
      mask_q <= '1;
`endif
    end else if (bus.pat_load) begin
      pat_q  <= bus.pat_in;
      fill   <= '0;
      dout   <= 1'b0;
`ifdef SEQDET_MASK_EN
      mask_q <= bus.mask_in;
`endif
    end else if (consume) begin
      sr   <= sr_n;
      // Non-overlapping mode restarts history collection after each hit.
      fill <= (match && !bus.overlap) ? '0 : fill_n;
      dout <= match;
    end else begin
      dout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.cnt_clr) begin
      cnt <= '0;
    end else if (match && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.dout      = dout;
  assign bus.match_cnt = cnt;
  assign bus.pat_q     = pat_q;
`ifdef SEQDET_MASK_EN
  assign bus.mask_q    = mask_q;
`endif
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence detector. Successor to the fixed 4-bit "1110" Moore detector.
- Pattern width, reset pattern and match-counter width are parameters. The pattern is reloadable at runtime.
- Supports overlapping and non-overlapping detection, a qualified input strobe and a saturating match counter.
- Sits on the serial bit stream between the input pad logic and downstream control.

Parameters:
- PAT_W, 4, pattern length in bits (2..32).
- PAT_RST, 4'b1110, pattern value after reset (PAT_W bits).
- CNT_W, 8, match counter width.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous reset, active-high.
- Din_vld  input  1  Din qualifier; a bit is consumed only when high.
- Din  input  1  serial data bit.
- Overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- Pat_load  input  1  load Pat_in into the pattern register.
- Pat_in  input  PAT_W  new pattern; MSB is the first bit received.
- Cnt_clr  input  1  synchronous clear of Match_cnt.
- Dout  output  1  one-cycle match pulse, registered.
- Match_cnt  output  CNT_W  saturating count of matches.
- Pat_q  output  PAT_W  current pattern register.

Behaviour:
- Reset (async, Reset=1):
  - history shift register = 0
  - fill counter = 0
  - Dout = 0
  - Match_cnt = 0
  - Pat_q = PAT_RST
- State:
  - shift register sr[PAT_W-1:0]
  - fill counter (0..PAT_W, saturating at PAT_W), giving the number of valid history bits
  - pattern register
  - Dout register
  - counter
- Consume, on a rising edge with Din_vld=1 and Pat_load=0:
  - sr_n = {sr[PAT_W-2:0], Din}
  - fill_n = min(fill+1, PAT_W)
- Match condition: fill_n == PAT_W and sr_n == Pat_q. Partial history never matches, so after reset or reload at least PAT_W consumed bits are needed.
- Dout:
  - On a match, Dout=1 in the cycle after the edge that consumed the final bit. Latency is 1 clock from the sampling edge.
  - Otherwise Dout=0, including cycles with Din_vld=0.
  - Dout is never high for two consecutive cycles unless consecutive consumed bits each complete a match.
- Overlap=1: after a match, sr and fill update normally, so the suffix of the matched bits can start the next match. Example: pattern 1111 on stream 11111 gives 2 matches.
- Overlap=0: on the matching edge fill is forced to 0 (sr value is don't-care). Pattern 1111 on stream 11111111 gives 2 matches, at bits 4 and 8.
- Overlap is sampled on the matching edge. A change mid-stream affects only subsequent matches.
- Din_vld=0: sr, fill and pattern hold, Dout=0. Gaps in the stream are transparent.
- Pat_load=1 at an edge:
  - Pat_q <= Pat_in
  - fill <= 0
  - Dout <= 0
  - any simultaneous Din bit is discarded (load wins)
- Match_cnt:
  - increments by 1 at each edge where a match is registered
  - saturates at 2^CNT_W-1, no wrap
  - Cnt_clr=1 sets 0; Cnt_clr wins over a simultaneous increment (result 0), but Dout still pulses
- Reset mid-stream: all history is discarded immediately, Dout drops asynchronously, and Pat_q returns to PAT_RST.

Optional Feature:
- Macro: SEQDET_MASK_EN.
- Defined:
  - Adds input Mask_in [PAT_W-1:0], loaded alongside Pat_in on Pat_load; reset value is all ones.
  - Adds output Mask_q.
  - Match condition becomes ((sr_n ^ Pat_q) & Mask_q) == 0 with fill_n == PAT_W. Mask bit 0 means don't-care.
  - An all-zero mask matches every consumed bit once fill is full.
- Not defined: no Mask ports, exact compare as above.

Test Plan:
- Reset, defaults, Overlap=1, Din_vld=1, stream 1,1,1,0 -> Dout=1 exactly one cycle after the 4th edge; Match_cnt=1.
- Pattern 1111, Overlap=1, eight consecutive 1s -> matches at bits 4..8, Match_cnt=5. Same with Overlap=0 -> matches at bits 4 and 8, Match_cnt=2.
- Stream 1,1,(Din_vld=0 for 3 cycles),1,0 -> single match after bit 4; no Dout during the gap.
- After 3 bits of 1110, pulse Pat_load with Pat_in=0101 and Din=0 that cycle -> bit discarded, Pat_q=0101, no match until 4 new bits 0,1,0,1 -> Dout pulse.
- CNT_W=2, 5 matches -> Match_cnt=3 (saturates). Cnt_clr asserted on a matching edge -> Match_cnt=0 and Dout=1. Reset asserted mid-stream -> Dout=0 and Match_cnt=0 immediately, Pat_q=1110.
- With SEQDET_MASK_EN: Pat=1110, Mask=1101, streams 1100 and 1110 -> both match; stream 0110 -> no match.
